// File: rtl/axi_arb2.sv
// axi_arb2: two-master to one-slave AXI arbiter.
// Master 0 is the instruction cache and master 1 is the data cache.
// Reads and writes are arbitrated separately, with one outstanding burst per channel.
// A grant is held until its burst completes. Responses are routed by the recorded grant.
// The optional macro ARB_RR_EN turns on round-robin arbitration per channel.
// With ARB_RR_EN undefined, master 1 has fixed priority over master 0.
// Handshake rule on every channel: a beat transfers on a rising clk edge where valid and
// ready are both high; a master holds valid and its payload stable until that edge.
// r_state_dbg and w_state_dbg expose the two FSM states (IDLE=0, ADDR=1, DATA=2, RESP=3).
module axi_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction cache)
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0]        s0_awlen,
  input  logic [2:0]        s0_awsize,
  input  logic [1:0]        s0_awburst,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [3:0]        s0_wstrb,
  input  logic              s0_wlast,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  // master 1 (data cache)
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0]        s1_awlen,
  input  logic [2:0]        s1_awsize,
  input  logic [1:0]        s1_awburst,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [3:0]        s1_wstrb,
  input  logic              s1_wlast,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  // slave side (CPU external AXI port)
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [3:0]        m_arid,
  output logic [1:0]        m_arlock,
  output logic [3:0]        m_arcache,
  output logic [2:0]        m_arprot,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [3:0]        m_rid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [3:0]        m_awid,
  output logic [1:0]        m_awlock,
  output logic [3:0]        m_awcache,
  output logic [2:0]        m_awprot,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [3:0]        m_wid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [3:0]        m_bid,
  // FSM state visibility
  output logic [1:0]        r_state_dbg,
  output logic [1:0]        w_state_dbg
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic     rg, wg;          // recorded grant per channel
  logic     r_pick, w_pick;  // arbitration winner while idle
  logic     r_start, w_start;

  // Routing never looks at the returned IDs.
  logic unused_ids;
  assign unused_ids = ^{m_rid, m_bid};

  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;

  assign r_start = (r_state == R_IDLE) && (s0_arvalid || s1_arvalid);
  assign w_start = (w_state == W_IDLE) && (s0_awvalid || s1_awvalid);

`ifdef ARB_RR_EN
  // r_last/w_last hold the last-granted master; reset to 0 so master 1 wins the first tie.
  logic r_last, w_last;
  assign r_pick = (s0_arvalid && s1_arvalid) ? ~r_last : s1_arvalid;
  assign w_pick = (s0_awvalid && s1_awvalid) ? ~w_last : s1_awvalid;

  // Round-robin pointers advance when a channel leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b0;
      w_last <= 1'b0;
    end else begin
      if (r_start) r_last <= r_pick;
      if (w_start) w_last <= w_pick;
    end
  end
`else
  // Fixed priority: the data cache wins any tie.
  assign r_pick = s1_arvalid;
  assign w_pick = s1_awvalid;
`endif

  // State registers and grant capture for both channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      rg      <= 1'b0;
      wg      <= 1'b0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (r_start) rg <= r_pick;
      if (w_start) wg <= w_pick;
    end
  end

  assign r_state_dbg = r_state;
  assign w_state_dbg = w_state;

  // Read channel: next state and AR/R steering; everything idles at 0.
  always_comb begin
    r_next = r_state;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = 1'b0; m_arid = '0;
    s0_arready = 1'b0; s1_arready = 1'b0; m_rready = 1'b0;
    s0_rdata = '0; s0_rresp = '0; s0_rlast = 1'b0; s0_rvalid = 1'b0;
    s1_rdata = '0; s1_rresp = '0; s1_rlast = 1'b0; s1_rvalid = 1'b0;
    case (r_state)
      R_IDLE: if (s0_arvalid || s1_arvalid) r_next = R_ADDR;
      R_ADDR: begin
        m_arvalid = 1'b1;
        m_arid    = {3'b000, rg};
        if (rg) begin
          m_araddr = s1_araddr; m_arlen = s1_arlen; m_arsize = s1_arsize; m_arburst = s1_arburst;
          s1_arready = m_arready;
        end else begin
          m_araddr = s0_araddr; m_arlen = s0_arlen; m_arsize = s0_arsize; m_arburst = s0_arburst;
          s0_arready = m_arready;
        end
        if (m_arready) r_next = R_DATA;
      end
      R_DATA: begin
        if (rg) begin
          s1_rdata = m_rdata; s1_rresp = m_rresp; s1_rlast = m_rlast; s1_rvalid = m_rvalid;
          m_rready = s1_rready;
        end else begin
          s0_rdata = m_rdata; s0_rresp = m_rresp; s0_rlast = m_rlast; s0_rvalid = m_rvalid;
          m_rready = s0_rready;
        end
        if (m_rvalid && m_rlast && (rg ? s1_rready : s0_rready)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write channel: next state and AW/W/B steering; W only flows after the AW handshake.
  always_comb begin
    w_next = w_state;
    m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = 1'b0; m_awid = '0;
    m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0; m_wid = '0; m_bready = 1'b0;
    s0_awready = 1'b0; s1_awready = 1'b0; s0_wready = 1'b0; s1_wready = 1'b0;
    s0_bresp = '0; s0_bvalid = 1'b0; s1_bresp = '0; s1_bvalid = 1'b0;
    case (w_state)
      W_IDLE: if (s0_awvalid || s1_awvalid) w_next = W_ADDR;
      W_ADDR: begin
        m_awvalid = 1'b1;
        m_awid    = {3'b000, wg};
        if (wg) begin
          m_awaddr = s1_awaddr; m_awlen = s1_awlen; m_awsize = s1_awsize; m_awburst = s1_awburst;
          s1_awready = m_awready;
        end else begin
          m_awaddr = s0_awaddr; m_awlen = s0_awlen; m_awsize = s0_awsize; m_awburst = s0_awburst;
          s0_awready = m_awready;
        end
        if (m_awready) w_next = W_DATA;
      end
      W_DATA: begin
        m_wid = {3'b000, wg};
        if (wg) begin
          m_wdata = s1_wdata; m_wstrb = s1_wstrb; m_wlast = s1_wlast; m_wvalid = s1_wvalid;
          s1_wready = m_wready;
        end else begin
          m_wdata = s0_wdata; m_wstrb = s0_wstrb; m_wlast = s0_wlast; m_wvalid = s0_wvalid;
          s0_wready = m_wready;
        end
        if (m_wready && (wg ? (s1_wvalid && s1_wlast) : (s0_wvalid && s0_wlast))) w_next = W_RESP;
      end
      W_RESP: begin
        if (wg) begin
          s1_bresp = m_bresp; s1_bvalid = m_bvalid; m_bready = s1_bready;
        end else begin
          s0_bresp = m_bresp; s0_bvalid = m_bvalid; m_bready = s0_bready;
        end
        if (m_bvalid && (wg ? s1_bready : s0_bready)) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arb2.sv
// tb_axi_arb2: directed bench for axi_arb2.
// A per-cycle read-channel table, then sequences for arbitration order, write routing,
// concurrent read/write, randomised backpressure and reset in the middle of a burst.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_axi_arb2;

  localparam logic [31:0] A0 = 32'h1FC0_0000;
  localparam logic [31:0] A1 = 32'h8000_0040;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_rdata, s1_rdata, s0_wdata, s1_wdata;
  logic [7:0]  s0_arlen, s1_arlen, s0_awlen, s1_awlen;
  logic [2:0]  s0_arsize, s1_arsize, s0_awsize, s1_awsize;
  logic [1:0]  s0_arburst, s1_arburst, s0_awburst, s1_awburst, s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready, s0_rlast, s1_rlast;
  logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready, s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
  logic [3:0]  m_arid, m_awid, m_wid, m_arcache, m_awcache, m_rid, m_bid, m_wstrb;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, m_awvalid, m_awready;
  logic        m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  r_state_dbg, w_state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];   // expected read beats / arbitration order
  logic [31:0] wexp_q[$];  // expected write beats

  axi_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
    .r_state_dbg(r_state_dbg), .w_state_dbg(w_state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_arvalid = 0; s0_rready = 0;
    s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_arvalid = 0; s1_rready = 0;
    s0_awaddr = '0; s0_awlen = '0; s0_awsize = '0; s0_awburst = '0; s0_awvalid = 0;
    s1_awaddr = '0; s1_awlen = '0; s1_awsize = '0; s1_awburst = '0; s1_awvalid = 0;
    s0_wdata = '0; s0_wstrb = '0; s0_wlast = 0; s0_wvalid = 0; s0_bready = 0;
    s1_wdata = '0; s1_wstrb = '0; s1_wlast = 0; s1_wvalid = 0; s1_bready = 0;
    m_arready = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0; m_rid = '0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0; m_bid = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; clear_inputs();
    @(negedge clk); rst = 1'b0;
  endtask

  function automatic logic [14:0] all_handshakes();
    return {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s0_arready, s1_arready,
            s0_rvalid, s1_rvalid, s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid};
  endfunction

  // read-channel table record
  typedef struct {
    logic s0_arv, s1_arv, m_ardy, m_rv, m_rl, s0_rr, s1_rr;
    logic [31:0] rd;
    logic e_marv; logic [3:0] e_arid; logic [31:0] e_araddr;
    logic e_s0a, e_s1a, e_s0rv, e_s1rv, e_mrr; logic [1:0] e_st;
  } rvec_t;
  rvec_t tbl[$];

  task automatic add(input logic s0v, s1v, mardy, mrv, mrl, s0rr, s1rr, input logic [31:0] rd,
                     input logic e_marv, input logic [3:0] e_arid, input logic [31:0] e_addr,
                     input logic e_s0a, e_s1a, e_s0rv, e_s1rv, e_mrr, input logic [1:0] e_st);
    rvec_t v;
    v.s0_arv = s0v; v.s1_arv = s1v; v.m_ardy = mardy; v.m_rv = mrv; v.m_rl = mrl;
    v.s0_rr = s0rr; v.s1_rr = s1rr; v.rd = rd; v.e_marv = e_marv; v.e_arid = e_arid;
    v.e_araddr = e_addr; v.e_s0a = e_s0a; v.e_s1a = e_s1a; v.e_s0rv = e_s0rv;
    v.e_s1rv = e_s1rv; v.e_mrr = e_mrr; v.e_st = e_st;
    tbl.push_back(v);
  endtask

  // driver: one read burst from master m, with slave model on m_ar*/m_r*
  task automatic do_read(input bit m, input logic [31:0] addr, input logic [7:0] len,
                         input bit bp, output int cyc);
    logic [31:0] rbase, e, s_rd;
    int sb, mb;
    bit ar_done, ar_hs, done, s_hs, m_hs;
    logic s_rv, s_rr, s_rl, s_ar, o_rv;
    rbase = addr ^ 32'hA5A5_0000; sb = 0; mb = 0; ar_done = 0; done = 0; cyc = 0;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(rbase + i);
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (m) begin
        s1_araddr = addr; s1_arlen = len; s1_arsize = 3'd2; s1_arburst = 2'd1; s1_arvalid = !ar_done;
        s1_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        s0_araddr = addr; s0_arlen = len; s0_arsize = 3'd2; s0_arburst = 2'd1; s0_arvalid = !ar_done;
        s0_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      m_arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_rvalid  = ar_done && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
      m_rdata   = rbase + sb; m_rlast = (sb == int'(len)); m_rresp = 2'b00;
      #1;
      s_rv = m ? s1_rvalid : s0_rvalid; s_rr = m ? s1_rready : s0_rready;
      s_rl = m ? s1_rlast : s0_rlast;   s_rd = m ? s1_rdata : s0_rdata;
      s_ar = m ? s1_arready : s0_arready; o_rv = m ? s0_rvalid : s1_rvalid;
      ar_hs = m_arvalid && m_arready; s_hs = s_rv && s_rr; m_hs = m_rvalid && m_rready;
      if (m_arvalid) begin
        chk("ar_addr", m_araddr, addr);
        chk("ar_len", m_arlen, len);
        chk("ar_id", m_arid, {3'b000, m});
      end
      if (ar_hs) chk("ar_ready_route", s_ar, 1);
      chk("r_other_quiet", o_rv, 0);
      chk("r_hs_pair", s_hs, m_hs);
      if (s_hs) begin
        if (exp_q.size() == 0) chk("r_extra_beat", 1, 0);
        else begin e = exp_q.pop_front(); chk("r_data", s_rd, e); end
        chk("r_last", s_rl, mb == int'(len));
        mb++;
        if (mb == int'(len) + 1) done = 1;
      end
      if (m_hs) sb++;
      if (ar_hs) ar_done = 1;
      cyc++;
    end
    chk("r_beat_count", mb, len + 1);
    exp_q.delete();
    @(negedge clk);
    m_rvalid = 0; m_arready = 0; m_rlast = 0;
    if (m) begin s1_rready = 0; s1_arvalid = 0; end else begin s0_rready = 0; s0_arvalid = 0; end
    #1;
    chk("r_back_idle", r_state_dbg, 0);
  endtask

  // driver: one write burst from master m, slave accepts AW from its third cycle on
  task automatic do_write(input bit m, input logic [31:0] addr, input logic [7:0] len, output int cyc);
    logic [31:0] e, wbase;
    int wb, mb;
    bit aw_done, w_done, b_done, aw_hs, w_last_hs;
    logic s_awr, s_wv, s_wr, s_bv, o_wr, o_bv;
    logic [1:0] s_br;
    wbase = 32'hC000_0000 + addr; wb = 0; mb = 0; aw_done = 0; w_done = 0; b_done = 0; cyc = 0;
    for (int i = 0; i <= int'(len); i++) wexp_q.push_back(wbase + i);
    while (!b_done && cyc < 400) begin
      @(negedge clk);
      if (m) begin
        s1_awaddr = addr; s1_awlen = len; s1_awsize = 3'd2; s1_awburst = 2'd1; s1_awvalid = !aw_done;
        s1_wdata = wbase + wb; s1_wstrb = 4'hF; s1_wlast = (wb == int'(len)); s1_wvalid = !w_done;
        s1_bready = 1'b1;
      end else begin
        s0_awaddr = addr; s0_awlen = len; s0_awsize = 3'd2; s0_awburst = 2'd1; s0_awvalid = !aw_done;
        s0_wdata = wbase + wb; s0_wstrb = 4'hF; s0_wlast = (wb == int'(len)); s0_wvalid = !w_done;
        s0_bready = 1'b1;
      end
      m_awready = (cyc >= 2); m_wready = 1'b1; m_bvalid = w_done; m_bresp = 2'b00;
      #1;
      s_awr = m ? s1_awready : s0_awready; s_wv = m ? s1_wvalid : s0_wvalid;
      s_wr = m ? s1_wready : s0_wready;    s_bv = m ? s1_bvalid : s0_bvalid;
      s_br = m ? s1_bresp : s0_bresp;      o_wr = m ? s0_wready : s1_wready;
      o_bv = m ? s0_bvalid : s1_bvalid;
      aw_hs = m_awvalid && m_awready; w_last_hs = 0;
      if (!aw_done) chk("w_before_aw", m_wvalid, 0);
      if (m_awvalid) begin
        chk("aw_addr", m_awaddr, addr);
        chk("aw_id", m_awid, {3'b000, m});
      end
      if (aw_hs) chk("aw_ready_route", s_awr, 1);
      chk("w_other_quiet", o_wr, 0);
      chk("b_other_quiet", o_bv, 0);
      if (m_wvalid && m_wready) begin
        if (wexp_q.size() == 0) chk("w_extra_beat", 1, 0);
        else begin e = wexp_q.pop_front(); chk("w_data", m_wdata, e); end
        chk("w_last", m_wlast, mb == int'(len));
        chk("w_strb", m_wstrb, 4'hF);
        chk("w_id", m_wid, {3'b000, m});
        mb++;
      end
      if (s_wv && s_wr) begin
        if (wb == int'(len)) w_last_hs = 1;
        wb++;
      end
      if (m_bvalid) begin
        chk("b_route", s_bv, 1);
        chk("b_resp", s_br, 2'b00);
        if (s_bv) b_done = 1;
      end
      if (aw_hs) aw_done = 1;
      if (w_last_hs) w_done = 1;
      cyc++;
    end
    chk("w_beat_count", mb, len + 1);
    chk("b_done", b_done, 1);
    wexp_q.delete();
    @(negedge clk);
    m_bvalid = 0; m_awready = 0; m_wready = 0;
    if (m) begin s1_awvalid = 0; s1_wvalid = 0; s1_bready = 0; end
    else   begin s0_awvalid = 0; s0_wvalid = 0; s0_bready = 0; end
    #1;
    chk("w_back_idle", w_state_dbg, 0);
  endtask

  initial begin
    int rc, wc, got;
    logic [31:0] e;
    rst = 1'b1;
    clear_inputs();

    // reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_handshakes", {17'd0, all_handshakes()}, 0);
    chk("rst_r_state", r_state_dbg, 0);
    chk("rst_w_state", w_state_dbg, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_awaddr", m_awaddr, 0);
    @(negedge clk); rst = 1'b0;

    // read-channel table: s0 burst of 8 (stall, gap, s1 waiting), then s1 single beat
    add(0,0,0,0,0,0,0, 32'h0,         0,0,'0, 0,0,0,0,0, 0);
    add(1,0,0,0,0,0,0, 32'h0,         0,0,'0, 0,0,0,0,0, 0);
    add(1,0,0,0,0,0,0, 32'h0,         1,0,A0, 0,0,0,0,0, 1);
    add(1,0,1,0,0,0,0, 32'h0,         1,0,A0, 1,0,0,0,0, 1);
    add(0,0,0,1,0,1,0, 32'h1000_0000, 0,0,'0, 0,0,1,0,1, 2);
    add(0,0,0,1,0,1,0, 32'h1000_0001, 0,0,'0, 0,0,1,0,1, 2);
    add(0,0,0,1,0,1,0, 32'h1000_0002, 0,0,'0, 0,0,1,0,1, 2);
    add(0,0,0,1,0,0,1, 32'h1000_0003, 0,0,'0, 0,0,1,0,0, 2);
    add(0,0,0,1,0,1,0, 32'h1000_0003, 0,0,'0, 0,0,1,0,1, 2);
    add(0,0,0,0,0,1,0, 32'h0,         0,0,'0, 0,0,0,0,1, 2);
    add(0,1,0,1,0,1,0, 32'h1000_0004, 0,0,'0, 0,0,1,0,1, 2);
    add(0,1,0,1,0,1,0, 32'h1000_0005, 0,0,'0, 0,0,1,0,1, 2);
    add(0,1,0,1,0,1,0, 32'h1000_0006, 0,0,'0, 0,0,1,0,1, 2);
    add(0,1,0,1,1,1,0, 32'h1000_0007, 0,0,'0, 0,0,1,0,1, 2);
    add(0,1,0,0,0,0,0, 32'h0,         0,0,'0, 0,0,0,0,0, 0);
    add(0,1,1,0,0,0,0, 32'h0,         1,1,A1, 0,1,0,0,0, 1);
    add(0,0,0,1,1,0,1, 32'h2000_0008, 0,0,'0, 0,0,0,1,1, 2);
    add(0,0,0,0,0,0,0, 32'h0,         0,0,'0, 0,0,0,0,0, 0);
    s0_araddr = A0; s0_arlen = 8'd7; s1_araddr = A1; s1_arlen = 8'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      s0_arvalid = tbl[i].s0_arv; s1_arvalid = tbl[i].s1_arv; m_arready = tbl[i].m_ardy;
      m_rvalid = tbl[i].m_rv; m_rlast = tbl[i].m_rl; s0_rready = tbl[i].s0_rr;
      s1_rready = tbl[i].s1_rr; m_rdata = tbl[i].rd;
      #1;
      chk($sformatf("t%0d_marvalid", i), m_arvalid, tbl[i].e_marv);
      chk($sformatf("t%0d_arid", i), m_arid, tbl[i].e_arid);
      chk($sformatf("t%0d_araddr", i), m_araddr, tbl[i].e_araddr);
      chk($sformatf("t%0d_arlen", i), m_arlen, tbl[i].e_marv ? (tbl[i].e_arid[0] ? 0 : 7) : 0);
      chk($sformatf("t%0d_s0_arready", i), s0_arready, tbl[i].e_s0a);
      chk($sformatf("t%0d_s1_arready", i), s1_arready, tbl[i].e_s1a);
      chk($sformatf("t%0d_s0_rvalid", i), s0_rvalid, tbl[i].e_s0rv);
      chk($sformatf("t%0d_s1_rvalid", i), s1_rvalid, tbl[i].e_s1rv);
      chk($sformatf("t%0d_m_rready", i), m_rready, tbl[i].e_mrr);
      chk($sformatf("t%0d_r_state", i), r_state_dbg, tbl[i].e_st);
      chk($sformatf("t%0d_s0_rdata", i), s0_rdata, tbl[i].e_s0rv ? tbl[i].rd : 32'h0);
      chk($sformatf("t%0d_s1_rdata", i), s1_rdata, tbl[i].e_s1rv ? tbl[i].rd : 32'h0);
      chk($sformatf("t%0d_s0_rlast", i), s0_rlast, tbl[i].e_s0rv ? tbl[i].m_rl : 1'b0);
    end

    // arbitration order with both masters requesting continuously
    pulse_reset();
`ifdef ARB_RR_EN
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
`else
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
`endif
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      s0_araddr = A0; s1_araddr = A1; s0_arlen = 0; s1_arlen = 0;
      s0_arvalid = 1; s1_arvalid = 1; s0_rready = 1; s1_rready = 1;
      m_arready = 1; m_rvalid = 1; m_rlast = 1;
      #1;
      if (m_arvalid && m_arready) begin
        e = exp_q.pop_front();
        chk($sformatf("arb_grant%0d", got), m_arid, e);
        chk($sformatf("arb_addr%0d", got), m_araddr, e[0] ? A1 : A0);
        got++;
      end
    end
    chk("arb_grants", got, 4);
    exp_q.delete();
    pulse_reset();

    // single write from s1
    do_write(1, 32'h0000_1000, 8'd3, wc);
    chk("wr_cycles", wc, 8);

    // concurrent read on s0 and write on s1
    fork
      do_read(0, 32'h0000_2000, 8'd3, 0, rc);
      do_write(1, 32'h0000_3000, 8'd3, wc);
    join
    chk("conc_rd_cycles", rc, 6);
    chk("conc_wr_cycles", wc, 8);

    // randomised backpressure on AR and R
    do_read(1, 32'h0000_4000, 8'd7, 1, rc);
    do_read(0, 32'h0000_5000, 8'd7, 1, rc);

    // reset asserted on the third beat of an 8-beat read
    @(negedge clk);
    s0_araddr = A0; s0_arlen = 8'd7; s0_arvalid = 1; s0_rready = 1; m_arready = 1;
    @(negedge clk);
    @(negedge clk); s0_arvalid = 0; m_rvalid = 1; m_rdata = 32'h11;
    @(negedge clk); m_rdata = 32'h12;
    @(negedge clk); m_rdata = 32'h13;
    #1;
    chk("mid_rst_beat3", s0_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_handshakes", {17'd0, all_handshakes()}, 0);
    chk("mid_rst_r_state", r_state_dbg, 0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    do_read(0, A0, 8'd7, 0, rc);
    chk("post_rst_rd_cycles", rc, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
